// File: rtl/mem_lsu.sv
// Load/store unit in front of a word-wide data memory; sub-word stores use read-modify-write.
// Optional MEM_LSU_ALIGN_CHECK_EN: flag misaligned or illegal-size requests as errors instead of masking address bits.
module mem_lsu #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W+1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_w_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_data_in,
    input  logic [31:0]       mem_data_out
);

    typedef enum logic [2:0] {IDLE, RD, WAIT, WR, RESP} state_t;

    state_t            state_q, state_d;
    logic              we_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic [1:0]        lane_q;
    logic [15:0]       wdata_q;
    logic              err_q;
    logic [31:0]       rbuf_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_data_q;

    logic accept;
    logic acc_err;
    logic word_store;

    function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] size,
                                            input logic [1:0] lane, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{lane, 3'b000} +: 8];
        h = w[{lane[1], 4'b0000} +: 16];
        case (size)
            2'b00:   extract = {{24{~uns & b[7]}}, b};
            2'b01:   extract = {{16{~uns & h[15]}}, h};
            default: extract = w;
        endcase
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] w, input logic [15:0] wd,
                                          input logic [1:0] size, input logic [1:0] lane);
        logic [31:0] r;
        r = w;
        case (size)
            2'b00:   r[{lane, 3'b000} +: 8] = wd[7:0];
            2'b01:   r[{lane[1], 4'b0000} +: 16] = wd;
            default: r = w;
        endcase
        return r;
    endfunction

    assign accept = req_valid && (state_q == IDLE);

`ifdef MEM_LSU_ALIGN_CHECK_EN
    assign acc_err = (req_size == 2'b11) ||
                     ((req_size == 2'b01) && req_addr[0]) ||
                     ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
`else
    assign acc_err = 1'b0;
`endif

    // size 1x is a full word (11 only reaches here when the alignment check is off)
    assign word_store = req_we && req_size[1] && !acc_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            we_q       <= 1'b0;
            size_q     <= 2'b00;
            uns_q      <= 1'b0;
            lane_q     <= 2'b00;
            wdata_q    <= '0;
            err_q      <= 1'b0;
            rbuf_q     <= '0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                we_q    <= req_we;
                size_q  <= req_size;
                uns_q   <= req_unsigned;
                lane_q  <= req_addr[1:0];
                wdata_q <= req_wdata[15:0];
                err_q   <= acc_err;
                if (!acc_err) mem_addr_q <= req_addr[ADDR_W+1:2];
                if (word_store) mem_data_q <= req_wdata;
            end
            // Sampling at the end of WAIT works for both combinational and registered reads
            if (state_q == WAIT) begin
                rbuf_q <= mem_data_out;
                if (we_q) mem_data_q <= merge(mem_data_out, wdata_q, size_q, lane_q);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (acc_err)         state_d = RESP;
                    else if (word_store) state_d = WR;
                    else                 state_d = RD;
                end
            end
            RD:      state_d = WAIT;
            WAIT:    state_d = we_q ? WR : RESP;
            WR:      state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign req_ready   = (state_q == IDLE);
    assign resp_valid  = (state_q == RESP);
    assign mem_w_en    = (state_q == WR);
    assign mem_addr    = mem_addr_q;
    assign mem_data_in = mem_data_q;
    assign resp_rdata  = ((state_q == RESP) && !we_q && !err_q) ?
                         extract(rbuf_q, size_q, lane_q, uns_q) : 32'h0;

`ifdef MEM_LSU_ALIGN_CHECK_EN
    assign resp_err = (state_q == RESP) && err_q;
`else
    assign resp_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_lsu.sv
// Scoreboard bench for mem_lsu with a behavioural 256 x 32 memory (combinational read).
module tb_mem_lsu;
    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_we = 1'b0;
    logic [1:0]        req_size = 2'b00;
    logic              req_unsigned = 1'b0;
    logic [ADDR_W+1:0] req_addr = '0;
    logic [31:0]       req_wdata = '0;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic              mem_w_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_data_in;
    logic [31:0]       mem_data_out;

    mem_lsu #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .mem_w_en(mem_w_en), .mem_addr(mem_addr),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:255];
    assign mem_data_out = mem[mem_addr];
    always @(posedge clk) if (mem_w_en) mem[mem_addr] <= mem_data_in;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;

    exp_t  sbq [$];
    string tagq[$];
    exp_t  mon_e;
    string mon_tag;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int wen_cnt = 0;
    int wen_cyc = 0;
    logic [7:0]  wen_addr = '0;
    logic [31:0] wen_data = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mem_w_en) begin
            wen_cnt++;
            wen_cyc  = cyc;
            wen_addr = mem_addr;
            wen_data = mem_data_in;
        end
        if (rst_n && resp_valid) begin
            if (sbq.size() == 0) begin
                chk("unexpected_resp", 32'd1, 32'd0);
            end else begin
                mon_e   = sbq.pop_front();
                mon_tag = tagq.pop_front();
                chk({mon_tag, ".rdata"}, resp_rdata, mon_e.rdata);
                chk({mon_tag, ".err"}, {31'd0, resp_err}, {31'd0, mon_e.err});
                chk({mon_tag, ".latency"}, cyc - mon_e.acc + 1, mon_e.lat);
            end
        end
    end

    // Called just after a falling edge; returns just after the falling edge following the accept edge.
    task automatic do_req(input string tag, input logic we, input logic [1:0] size, input logic uns,
                          input logic [9:0] addr, input logic [31:0] wdata,
                          input logic [31:0] er, input logic ee, input int el, output int acc);
        int   n;
        exp_t e;
        n = 0;
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk({tag, ".accept_timeout"}, 32'd0, 32'd1);
            req_valid = 1'b0;
            acc = -1;
            return;
        end
        acc = cyc + 1;
        e.rdata = er; e.err = ee; e.lat = el; e.acc = acc;
        sbq.push_back(e);
        tagq.push_back(tag);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() != 0) begin
            chk({tag, ".resp_timeout"}, 32'd0, 32'd1);
            sbq.delete();
            tagq.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int a, b, w0, n;

        repeat (3) @(negedge clk);
        chk("rst.req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst.resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst.resp_rdata", resp_rdata, 32'd0);
        chk("rst.resp_err", {31'd0, resp_err}, 32'd0);
        chk("rst.mem_w_en", {31'd0, mem_w_en}, 32'd0);
        chk("rst.mem_addr", {24'd0, mem_addr}, 32'd0);
        chk("rst.mem_data_in", mem_data_in, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        w0 = wen_cnt;
        do_req("st_w_004", 1'b1, 2'b10, 1'b0, 10'h004, 32'h12345678, 32'h0, 1'b0, 2, a);
        wait_done("st_w_004");
        chk("st_w_004.wen_count", wen_cnt - w0, 32'd1);
        chk("st_w_004.wen_addr", {24'd0, wen_addr}, 32'd1);
        chk("st_w_004.wen_data", wen_data, 32'h12345678);
        chk("st_w_004.wen_cycle", wen_cyc - a + 1, 32'd1);

        do_req("st_w_008", 1'b1, 2'b10, 1'b0, 10'h008, 32'h87654321, 32'h0, 1'b0, 2, a);
        wait_done("st_w_008");

        w0 = wen_cnt;
        do_req("ld_w_004", 1'b0, 2'b10, 1'b0, 10'h004, 32'h0, 32'h12345678, 1'b0, 3, a);
        wait_done("ld_w_004");
        chk("ld_w_004.wen_count", wen_cnt - w0, 32'd0);

        w0 = wen_cnt;
`ifdef MEM_LSU_ALIGN_CHECK_EN
        do_req("ld_w_006", 1'b0, 2'b10, 1'b0, 10'h006, 32'h0, 32'h0, 1'b1, 1, a);
        wait_done("ld_w_006");
        do_req("ld_sz3_004", 1'b0, 2'b11, 1'b0, 10'h004, 32'h0, 32'h0, 1'b1, 1, a);
        wait_done("ld_sz3_004");
        do_req("ld_h_009", 1'b0, 2'b01, 1'b0, 10'h009, 32'h0, 32'h0, 1'b1, 1, a);
        wait_done("ld_h_009");
`else
        do_req("ld_w_006", 1'b0, 2'b10, 1'b0, 10'h006, 32'h0, 32'h12345678, 1'b0, 3, a);
        wait_done("ld_w_006");
        do_req("ld_sz3_004", 1'b0, 2'b11, 1'b0, 10'h004, 32'h0, 32'h12345678, 1'b0, 3, a);
        wait_done("ld_sz3_004");
        do_req("ld_h_009", 1'b0, 2'b01, 1'b0, 10'h009, 32'h0, 32'h00004321, 1'b0, 3, a);
        wait_done("ld_h_009");
`endif
        chk("loads.wen_count", wen_cnt - w0, 32'd0);

        do_req("ld_bu_007", 1'b0, 2'b00, 1'b1, 10'h007, 32'h0, 32'h00000012, 1'b0, 3, a);
        wait_done("ld_bu_007");

        do_req("st_b_005", 1'b1, 2'b00, 1'b0, 10'h005, 32'h00000080, 32'h0, 1'b0, 4, a);
        wait_done("st_b_005");
        chk("st_b_005.word1", mem[1], 32'h12348078);
        chk("st_b_005.wen_cycle", wen_cyc - a + 1, 32'd3);

        do_req("ld_bs_005", 1'b0, 2'b00, 1'b0, 10'h005, 32'h0, 32'hFFFFFF80, 1'b0, 3, a);
        do_req("ld_bu_005", 1'b0, 2'b00, 1'b1, 10'h005, 32'h0, 32'h00000080, 1'b0, 3, a);
        wait_done("ld_b_005");

        do_req("st_h_00A", 1'b1, 2'b01, 1'b0, 10'h00A, 32'h0000BEEF, 32'h0, 1'b0, 4, a);
        wait_done("st_h_00A");
        chk("st_h_00A.word2", mem[2], 32'hBEEF4321);

        do_req("ld_hu_00A", 1'b0, 2'b01, 1'b1, 10'h00A, 32'h0, 32'h0000BEEF, 1'b0, 3, a);
        do_req("ld_hs_00A", 1'b0, 2'b01, 1'b0, 10'h00A, 32'h0, 32'hFFFFBEEF, 1'b0, 3, a);
        do_req("ld_hs_008", 1'b0, 2'b01, 1'b0, 10'h008, 32'h0, 32'h00004321, 1'b0, 3, a);
        wait_done("ld_h");

        // Second request is presented while the first is in flight and must wait for req_ready
        do_req("b2b_a", 1'b0, 2'b10, 1'b0, 10'h004, 32'h0, 32'h12348078, 1'b0, 3, a);
        do_req("b2b_b", 1'b0, 2'b00, 1'b1, 10'h004, 32'h0, 32'h00000078, 1'b0, 3, b);
        wait_done("b2b");
        chk("b2b.accept_gap", b - a, 32'd4);

        // Reset in WAIT of a halfword store
        w0 = wen_cnt;
        n = 0;
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b01; req_unsigned = 1'b0;
        req_addr = 10'h008; req_wdata = 32'h00001111;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("rstmid.mem_addr_before", {24'd0, mem_addr}, 32'd2);
        rst_n = 1'b0;
        #1;
        chk("rstmid.req_ready", {31'd0, req_ready}, 32'd1);
        chk("rstmid.resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rstmid.mem_w_en", {31'd0, mem_w_en}, 32'd0);
        chk("rstmid.mem_addr", {24'd0, mem_addr}, 32'd0);
        chk("rstmid.mem_data_in", mem_data_in, 32'd0);
        chk("rstmid.resp_rdata", resp_rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rstmid.wen_count", wen_cnt - w0, 32'd0);
        chk("rstmid.word2", mem[2], 32'hBEEF4321);
        do_req("rstmid.ld_w_008", 1'b0, 2'b10, 1'b0, 10'h008, 32'h0, 32'hBEEF4321, 1'b0, 3, a);
        wait_done("rstmid.ld_w_008");

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_lsu.md
# mem_lsu

Load/store unit that sits directly upstream of the word-wide data memory `Mem`, which has a 256 × 32-bit array and ports `clk`, `w_en`, `addr[7:0]`, `data_in`, `data_out`.
- Accepts byte, halfword and word requests from the pipeline over a valid/ready handshake.
- Translates each request into word accesses on `Mem`. Sub-word stores use read-modify-write.
- Returns sign- or zero-extended load data with a one-cycle response pulse.

## Interface
- `ADDR_W`, default 8: `Mem` word-address width. The byte address is `ADDR_W+2` bits.
- `clk  in  1`: clock. All state updates on the rising edge.
- `rst_n  in  1`: asynchronous active-low reset.
- `req_valid  in  1`: request present.
- `req_ready  out  1`: unit idle and able to accept a request.
- `req_we  in  1`: 1 = store, 0 = load.
- `req_size  in  2`: 00 byte, 01 halfword, 10 word, 11 illegal.
- `req_unsigned  in  1`: loads only; 1 = zero-extend, 0 = sign-extend.
- `req_addr  in  ADDR_W+2`: byte address. Word index is `[ADDR_W+1:2]`; lane is `[1:0]`.
- `req_wdata  in  32`: store data, right-aligned.
- `resp_valid  out  1`: one-cycle completion pulse.
- `resp_rdata  out  32`: extended load data; 0 for stores and errors.
- `resp_err  out  1`: misaligned or illegal-size request. Meaningful only while `resp_valid` is high.
- `mem_w_en  out  1`: to `Mem.w_en`.
- `mem_addr  out  ADDR_W`: to `Mem.addr`.
- `mem_data_in  out  32`: to `Mem.data_in`.
- `mem_data_out  in  32`: from `Mem.data_out`.

## Operation
- States: IDLE, RD, WAIT, WR, RESP.
- `req_ready = (state == IDLE)`. A request is accepted on an edge where `req_valid && req_ready`; all `req_*` fields are latched at that edge.
- Routing on accept:
  - Error (see Configuration) → RESP with `resp_err = 1`.
  - Word store → WR.
  - Any other access → RD.
- RD: drive `mem_addr` = latched word index with `mem_w_en = 0`.
- WAIT: hold `mem_addr`. Capture `mem_data_out` into the read buffer at the end of WAIT. This is correct for both combinational and registered `Mem` reads.
- WAIT → WR for sub-word stores; WAIT → RESP for loads.
- WR: `mem_w_en = 1` for exactly one cycle, then → RESP.
  - Word store: `mem_data_in = req_wdata`.
  - Byte store: read buffer with lane `addr[1:0]` replaced by `wdata[7:0]`.
  - Halfword store: half `addr[1]` replaced by `wdata[15:0]`.
- RESP: `resp_valid = 1` for one cycle, then → IDLE.
- Load extraction:
  - Byte: lane `addr[1:0]`, extended from bit 7.
  - Half: bits `[16*addr[1] +: 16]`, extended from bit 15.
  - Word: unchanged.
  - `req_unsigned` selects zero-extension instead of sign-extension.
- `mem_w_en` is 0 in every state except WR.
- `mem_addr` and `mem_data_in` are registered outputs and hold their last value outside RD/WAIT/WR.

## Timing
- Latencies, counted from accept edge E:
  - Word store: WR during cycle E+1, `resp_valid` during E+2.
  - Load: `resp_valid` during E+3.
  - Sub-word store: write during E+3, `resp_valid` during E+4.
  - Error: `resp_valid` during E+1.
- `req_ready` returns to 1 in the cycle after RESP.
- Back-to-back throughput: one request per (latency+1) cycles.
- Reset values: state IDLE, `req_ready` 1, `resp_valid` 0, `resp_rdata` 0, `resp_err` 0, `mem_w_en` 0, `mem_addr` 0, `mem_data_in` 0, read buffer 0.
- Reset mid-operation: outputs take reset values immediately and the request is dropped. A sub-word store reset before its WR edge leaves memory unchanged.
- `req_valid` while not ready is ignored. The requester must hold the request until accepted.

## Configuration
- `MEM_LSU_ALIGN_CHECK_EN` defined:
  - `req_size == 11`, halfword with `addr[0] = 1`, or word with `addr[1:0] != 0` is an error.
  - An error request makes no memory access and gets `resp_err = 1`, `resp_rdata = 0` at E+1.
- `MEM_LSU_ALIGN_CHECK_EN` undefined:
  - No alignment checks; `resp_err` is tied to 0.
  - Low address bits below the access size are ignored: halfword uses `addr[1]`, word ignores `addr[1:0]`.
  - `req_size == 11` is treated as word.

## Test plan
- Store word `0x004` with `0x12345678` → `mem_w_en` high exactly one cycle at E+1 with `mem_addr = 1` and `mem_data_in = 0x12345678`; `resp_valid` at E+2.
- Load word `0x004` → `resp_rdata = 0x12345678` at E+3; `mem_w_en` never asserted. Load byte `0x007` unsigned → `0x00000012`.
- Store byte `0x005` with `0x80` → word 1 becomes `0x12348078`. Load byte `0x005` signed → `0xFFFFFF80`; unsigned → `0x00000080`.
- Word 2 preloaded with `0x87654321`; store half `0x00A` with `0x0000BEEF` → word 2 becomes `0xBEEF4321`. Load half `0x00A` unsigned → `0x0000BEEF`; signed → `0xFFFFBEEF`.
- Load word `0x006`:
  - Macro defined → `resp_err = 1`, `resp_rdata = 0` at E+1, no memory access.
  - Macro undefined → `resp_rdata = 0x12345678`, `resp_err = 0`.
- Assert `rst_n = 0` during WAIT of a store half → immediate reset values, `req_ready = 1`, word unchanged on a later read. Also hold `req_valid` during a busy period → second request accepted only when `req_ready` is 1.
